// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the decoder/regfile side and the HI/LO multiply/divide unit.
// The master issues ops and MF reads; the slave owns HI/LO and reports busy/stall/done.
interface muldiv_sequencer_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             mf_req;
   logic             busy;
   logic             stall;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             div_zero;

   modport master (
      output start, op, a, b, mf_req,
      input  busy, stall, done, hi, lo, div_zero
   );

   modport slave (
      input  start, op, a, b, mf_req,
      output busy, stall, done, hi, lo, div_zero
   );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with sign fix-up before the single HI/LO write.
module muldiv_sequencer #(
   parameter int unsigned WIDTH  = 32,
   parameter bit          DIV_EN = 1'b1
) (
   input logic               clk,
   input logic               reset,
   muldiv_sequencer_if.slave bus
);
   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

   state_e             state_q;
   logic               div_q, zero_q, neg_q, rneg_q, done_q, dz_q;
   logic [CW-1:0]      count_q;
   logic [WIDTH-1:0]   m_q, hi_q, lo_q;
   logic [2*WIDTH-1:0] p_q;

   logic               signed_op, b_zero, div_ge;
   logic [WIDTH-1:0]   mag_a, mag_b, div_diff, quot, rem;
   logic [WIDTH:0]     mul_sum, div_sh;
   logic [2*WIDTH-1:0] mul_next, div_next, mul_res;

   // p_q: multiply = {partial product, remaining multiplier bits};
   //      divide   = {partial remainder, dividend bits shifting into quotient}.
   always_comb begin
      signed_op = bus.op[0];
      b_zero    = (bus.b == '0);
      mag_a     = (signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
      mag_b     = (signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;
      mul_sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, m_q & {WIDTH{p_q[0]}}};
      mul_next  = {mul_sum, p_q[WIDTH-1:1]};
      div_sh    = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
      div_ge    = (div_sh >= {1'b0, m_q});
      div_diff  = div_ge ? WIDTH'(div_sh - {1'b0, m_q}) : div_sh[WIDTH-1:0];
      div_next  = {div_diff, p_q[WIDTH-2:0], div_ge};
      mul_res   = neg_q ? -p_q : p_q;
      quot      = neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
      rem       = rneg_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         div_q   <= 1'b0;
         zero_q  <= 1'b0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
         count_q <= '0;
         m_q     <= '0;
         p_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  div_q   <= bus.op[1];
                  dz_q    <= 1'b0;
                  zero_q  <= 1'b0;
                  count_q <= '0;
                  if (bus.op[1] && !DIV_EN) begin
                     done_q <= 1'b1;
                  end else if (bus.op[1] && b_zero) begin
                     zero_q  <= 1'b1;
                     p_q     <= {bus.a, {WIDTH{1'b1}}};
                     state_q <= StFix;
                  end else begin
                     neg_q   <= signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                     rneg_q  <= signed_op & bus.a[WIDTH-1];
                     m_q     <= bus.op[1] ? mag_b : mag_a;
                     p_q     <= {{WIDTH{1'b0}}, bus.op[1] ? mag_a : mag_b};
                     state_q <= StCalc;
                  end
               end
            end
            StCalc: begin
               p_q     <= div_q ? div_next : mul_next;
               count_q <= count_q + CW'(1);
               if (count_q == CW'(WIDTH - 1)) state_q <= StFix;
            end
            StFix: begin
               state_q <= StIdle;
               done_q  <= 1'b1;
               if (zero_q) begin
                  {hi_q, lo_q} <= p_q;
                  dz_q         <= 1'b1;
               end else if (div_q) begin
                  hi_q <= rem;
                  lo_q <= quot;
               end else begin
                  {hi_q, lo_q} <= mul_res;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.busy     = (state_q != StIdle);
   assign bus.stall    = bus.busy & (bus.start | bus.mf_req);
   assign bus.done     = done_q;
   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;
   assign bus.div_zero = dz_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases, randomized ops against
// a plain-arithmetic HI/LO model, stall/back-to-back behaviour, mid-op reset, DIV_EN=0.
module tb_muldiv_sequencer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_tests = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   muldiv_sequencer_if #(.WIDTH(32)) bus ();
   muldiv_sequencer_if #(.WIDTH(32)) bus_nd ();

   muldiv_sequencer #(.WIDTH(32), .DIV_EN(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   muldiv_sequencer #(.WIDTH(32), .DIV_EN(1'b0)) dut_nd (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_nd)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: HI/LO from plain 64-bit arithmetic.
   function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo,
                                 output logic dz);
      logic [63:0] p;
      longint      sa, sb, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      dz = 1'b0;
      case (op)
         2'd0: p = {32'b0, a} * {32'b0, b};
         2'd1: p = 64'(sa * sb);
         default: begin
            if (b == 32'd0) begin
               p  = {a, 32'hFFFF_FFFF};
               dz = 1'b1;
            end else if (op == 2'd2) begin
               p = {a % b, a / b};
            end else begin
               q = sa / sb;
               r = sa % sb;
               p = {r[31:0], q[31:0]};
            end
         end
      endcase
      hi = p[63:32];
      lo = p[31:0];
   endfunction

   function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
      return (op[1] && b == 32'd0) ? 2 : 34;
   endfunction

   // Issue one op from idle; report edges until done (accept edge counts as 1) and whether
   // HI/LO moved before done.
   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output bit torn);
      logic [31:0] hi0, lo0;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      hi0       = bus.hi;
      lo0       = bus.lo;
      lat       = 1;
      torn      = 1'b0;
      while (bus.done !== 1'b1 && lat < 100) begin
         if (bus.hi !== hi0 || bus.lo !== lo0) torn = 1'b1;
         tick();
         lat++;
      end
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h8000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'($urandom_range(0, 20));
         3: return -32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      n_tests += 4;
      if (bus.busy !== 1'b0 || bus.stall !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_busy_stall: busy=%b stall=%b required 0 0", bus.busy, bus.stall);
      end
      if (bus.done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_done: got %b required 0", bus.done);
      end
      if (bus.div_zero !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_div_zero: got %b required 0", bus.div_zero);
      end
      if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_hilo: got %h_%h required 0_0", bus.hi, bus.lo);
      end
   endtask

   task automatic test_directed();
      logic [1:0]  ops [6] = '{2'd0, 2'd1, 2'd3, 2'd3, 2'd2, 2'd2};
      logic [31:0] as  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h8000_0000,
                               32'd5, 32'd100};
      logic [31:0] bs  [6] = '{32'd2, 32'd7, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd7};
      logic [31:0] ehi [6] = '{32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'd5, 32'd2};
      logic [31:0] elo [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'h8000_0000,
                               32'hFFFF_FFFF, 32'd14};
      logic        edz [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      int          elat[6] = '{34, 34, 34, 34, 2, 34};
      int          lat;
      bit          torn;
      for (int i = 0; i < 6; i++) begin
         do_op(ops[i], as[i], bs[i], lat, torn);
         n_tests += 4;
         if (lat != elat[i]) begin
            n_fail++;
            $display("FAIL dir%0d_latency: got %0d required %0d", i, lat, elat[i]);
         end
         if (bus.hi !== ehi[i] || bus.lo !== elo[i] || torn) begin
            n_fail++;
            $display("FAIL dir%0d_hilo: got %h_%h torn=%b required %h_%h", i, bus.hi, bus.lo,
                     torn, ehi[i], elo[i]);
         end
         if (bus.div_zero !== edz[i]) begin
            n_fail++;
            $display("FAIL dir%0d_div_zero: got %b required %b", i, bus.div_zero, edz[i]);
         end
         tick();
         if (bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL dir%0d_done_pulse: done still %b one cycle later", i, bus.done);
         end
      end
   endtask

   task automatic test_random();
      logic [1:0]  op;
      logic [31:0] a, b, ehi, elo;
      logic        edz;
      int          lat;
      bit          torn;
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = pick();
         b  = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
         model(op, a, b, ehi, elo, edz);
         do_op(op, a, b, lat, torn);
         n_tests += 2;
         if (lat != exp_lat(op, b)) begin
            n_fail++;
            $display("FAIL rnd%0d_latency: op=%0d got %0d required %0d", i, op, lat,
                     exp_lat(op, b));
         end
         if (bus.hi !== ehi || bus.lo !== elo || bus.div_zero !== edz || torn) begin
            n_fail++;
            $display("FAIL rnd%0d_result: op=%0d a=%h b=%h got %h_%h dz=%b torn=%b required %h_%h dz=%b",
                     i, op, a, b, bus.hi, bus.lo, bus.div_zero, torn, ehi, elo, edz);
         end
      end
   endtask

   task automatic test_mf_stall();
      logic [31:0] ehi, elo;
      logic        edz;
      int          n;
      bus.op     = 2'd1;
      bus.a      = 32'hFFFF_FFFD;
      bus.b      = 32'd7;
      bus.start  = 1'b1;
      bus.mf_req = 1'b1;
      #1;
      n_tests++;
      if (bus.stall !== 1'b0) begin
         n_fail++;
         $display("FAIL mf_start_idle_stall: got %b required 0", bus.stall);
      end
      tick();
      bus.start = 1'b0;
      n = 0;
      while (bus.done !== 1'b1 && n < 100) begin
         n_tests++;
         if (bus.stall !== 1'b1) begin
            n_fail++;
            $display("FAIL mf_busy_stall: cycle %0d got %b required 1", n, bus.stall);
         end
         tick();
         n++;
      end
      model(2'd1, 32'hFFFF_FFFD, 32'd7, ehi, elo, edz);
      n_tests += 2;
      if (bus.stall !== 1'b0 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mf_done_stall: stall=%b busy=%b required 0 0", bus.stall, bus.busy);
      end
      if (bus.hi !== ehi || bus.lo !== elo || n != 33) begin
         n_fail++;
         $display("FAIL mf_result: got %h_%h after %0d required %h_%h after 33", bus.hi, bus.lo,
                  n, ehi, elo);
      end
      bus.mf_req = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] h1, l1, h2, l2;
      logic        dz;
      int          n;
      bit          torn;
      model(2'd0, 32'h1234_5678, 32'h9ABC_DEF0, h1, l1, dz);
      model(2'd2, 32'hDEAD_BEEF, 32'd1000, h2, l2, dz);
      bus.op    = 2'd0;
      bus.a     = 32'h1234_5678;
      bus.b     = 32'h9ABC_DEF0;
      bus.start = 1'b1;
      tick();
      bus.op = 2'd2;
      bus.a  = 32'hDEAD_BEEF;
      bus.b  = 32'd1000;
      n = 0;
      while (bus.done !== 1'b1 && n < 100) begin
         n_tests++;
         if (bus.stall !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_held_stall: cycle %0d got %b required 1", n, bus.stall);
         end
         tick();
         n++;
      end
      n_tests += 2;
      if (bus.hi !== h1 || bus.lo !== l1) begin
         n_fail++;
         $display("FAIL b2b_first: got %h_%h required %h_%h", bus.hi, bus.lo, h1, l1);
      end
      if (bus.stall !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_idle_stall: got %b required 0", bus.stall);
      end
      tick();
      bus.start = 1'b0;
      n_tests++;
      if (bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_accept: busy=%b required 1 after first idle cycle", bus.busy);
      end
      n    = 1;
      torn = 1'b0;
      while (bus.done !== 1'b1 && n < 100) begin
         if (bus.hi !== h1 || bus.lo !== l1) torn = 1'b1;
         tick();
         n++;
      end
      n_tests++;
      if (bus.hi !== h2 || bus.lo !== l2 || n != 34 || torn) begin
         n_fail++;
         $display("FAIL b2b_second: got %h_%h lat=%0d torn=%b required %h_%h lat=34", bus.hi,
                  bus.lo, n, torn, h2, l2);
      end
   endtask

   task automatic test_reset_mid_op();
      bit saw_done;
      bus.op    = 2'd0;
      bus.a     = 32'hFFFF_FFFF;
      bus.b     = 32'hFFFF_FFFF;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_tests += 2;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_state: busy=%b done=%b required 0 0", bus.busy, bus.done);
      end
      if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
         n_fail++;
         $display("FAIL midreset_hilo: got %h_%h required 0_0", bus.hi, bus.lo);
      end
      saw_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done === 1'b1) saw_done = 1'b1;
         tick();
      end
      n_tests++;
      if (saw_done || bus.hi !== 32'd0) begin
         n_fail++;
         $display("FAIL midreset_no_done: saw_done=%b hi=%h required 0 0", saw_done, bus.hi);
      end
   endtask

   task automatic test_div_disabled();
      int n;
      bus_nd.op    = 2'd0;
      bus_nd.a     = 32'd6;
      bus_nd.b     = 32'd7;
      bus_nd.start = 1'b1;
      tick();
      bus_nd.start = 1'b0;
      n = 1;
      while (bus_nd.done !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      n_tests++;
      if (bus_nd.lo !== 32'd42 || bus_nd.hi !== 32'd0 || n != 34) begin
         n_fail++;
         $display("FAIL nodiv_mul: got %h_%h lat=%0d required 0_2a lat=34", bus_nd.hi,
                  bus_nd.lo, n);
      end
      bus_nd.op    = 2'd3;
      bus_nd.a     = 32'd100;
      bus_nd.b     = 32'd0;
      bus_nd.start = 1'b1;
      tick();
      bus_nd.start = 1'b0;
      n_tests += 2;
      if (bus_nd.done !== 1'b1 || bus_nd.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL nodiv_done: done=%b busy=%b required 1 0", bus_nd.done, bus_nd.busy);
      end
      if (bus_nd.lo !== 32'd42 || bus_nd.hi !== 32'd0 || bus_nd.div_zero !== 1'b0) begin
         n_fail++;
         $display("FAIL nodiv_hilo: got %h_%h dz=%b required 0_2a dz=0", bus_nd.hi, bus_nd.lo,
                  bus_nd.div_zero);
      end
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.op        = 2'd0;
      bus.a         = '0;
      bus.b         = '0;
      bus.mf_req    = 1'b0;
      bus_nd.start  = 1'b0;
      bus_nd.op     = 2'd0;
      bus_nd.a      = '0;
      bus_nd.b      = '0;
      bus_nd.mf_req = 1'b0;
      test_reset();
      test_directed();
      test_random();
      test_mf_stall();
      tick();
      test_back_to_back();
      tick();
      test_reset_mid_op();
      test_div_disabled();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
